// File: rtl/pico_io_pkg.sv
// Register offsets and STATUS bit positions shared by the PicoBlaze I/O port blocks.
package pico_io_pkg;

  localparam logic [7:0] REG_STATUS   = 8'd0;
  localparam logic [7:0] REG_RX_DATA  = 8'd1;
  localparam logic [7:0] REG_LED      = 8'd2;
  localparam logic [7:0] REG_IRQ_MASK = 8'd3;
  localparam logic [7:0] REG_TX_DATA  = 8'd4;

  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_RX_FULL      = 1;
  localparam int ST_RX_OVERFLOW  = 2;
  localparam int ST_TX_VALID     = 3;

endpackage

// File: rtl/pico_io_fifo.sv
// Small synchronous RX FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module pico_io_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           data_i,
  output logic [W-1:0]           data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when a pop frees the slot at the same edge.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pico_io_port.sv
// PicoBlaze-style I/O port: STATUS, RX FIFO, LED, IRQ mask and TX register.
// Define PICO_IO_KWRITE_EN to let k_write_strobe qualify LED and TX_DATA writes.
module pico_io_port
  import pico_io_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] BASE_ID    = 8'h00
) (
  input  logic       clk,
  input  logic       cpu_reset,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       k_write_strobe,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] led_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0] in_port_q, in_port_d;
  logic [7:0] led_q, led_d;
  logic [2:0] mask_q, mask_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       ovf_q, ovf_d;
  logic       irq_q, irq_d;

  logic hit_status, hit_rx, hit_led, hit_mask, hit_tx;
  logic kw;
  logic wr_status, wr_led, wr_mask, wr_tx;
  logic rx_push, rx_pop, rx_full, rx_empty, ovf_event, irq_cond;
  logic [7:0]    rx_head, status;
  logic [CW-1:0] rx_count_unused;

  assign hit_status = (port_id == BASE_ID + REG_STATUS);
  assign hit_rx     = (port_id == BASE_ID + REG_RX_DATA);
  assign hit_led    = (port_id == BASE_ID + REG_LED);
  assign hit_mask   = (port_id == BASE_ID + REG_IRQ_MASK);
  assign hit_tx     = (port_id == BASE_ID + REG_TX_DATA);

`ifdef PICO_IO_KWRITE_EN
  assign kw = k_write_strobe;
`else
  logic unused_kwrite;
  assign kw            = 1'b0;
  assign unused_kwrite = k_write_strobe;
`endif

  assign wr_status = write_strobe & hit_status;
  assign wr_mask   = write_strobe & hit_mask;
  assign wr_led    = (write_strobe | kw) & hit_led;
  assign wr_tx     = (write_strobe | kw) & hit_tx;

  // Handshakes: a byte moves on rx (resp. tx) at a rising edge where valid and
  // ready are both high; a producer holds data stable while valid is high.
  // The one exception is a full RX FIFO, which still accepts a byte when a CPU
  // pop happens at the same edge even though rx_ready is low.
  assign rx_pop    = read_strobe & hit_rx & ~rx_empty;
  assign rx_push   = rx_valid & (~rx_full | rx_pop);
  assign ovf_event = rx_valid & rx_full & ~rx_pop;
  assign rx_ready  = ~rx_full;

  pico_io_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk     (clk),
    .rst     (cpu_reset),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .data_i  (rx_data),
    .data_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count_unused)
  );

  always_comb begin
    status                  = '0;
    status[ST_RX_NOT_EMPTY] = ~rx_empty;
    status[ST_RX_FULL]      = rx_full;
    status[ST_RX_OVERFLOW]  = ovf_q;
    status[ST_TX_VALID]     = tx_valid_q;
  end

  assign irq_cond = (~rx_empty & mask_q[0]) | (ovf_q & mask_q[1]) | (~tx_valid_q & mask_q[2]);

  always_comb begin
    in_port_d  = 8'h00;
    led_d      = led_q;
    mask_d     = mask_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    ovf_d      = ovf_q;
    irq_d      = interrupt_ack ? 1'b0 : irq_cond;

    if (hit_status)    in_port_d = status;
    else if (hit_rx)   in_port_d = rx_head;
    else if (hit_led)  in_port_d = led_q;
    else if (hit_mask) in_port_d = {5'b0, mask_q};
    else if (hit_tx)   in_port_d = tx_data_q;

    if (wr_led)  led_d  = out_port;
    if (wr_mask) mask_d = out_port[2:0];

    // A fresh overflow at the same edge as the clear keeps the flag set.
    if (ovf_event)                                   ovf_d = 1'b1;
    else if (wr_status && out_port[ST_RX_OVERFLOW]) ovf_d = 1'b0;

    if (tx_valid_q) begin
      if (tx_ready) tx_valid_d = 1'b0;
    end else if (wr_tx) begin
      tx_data_d  = out_port;
      tx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cpu_reset) begin
      in_port_q  <= '0;
      led_q      <= '0;
      mask_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      in_port_q  <= in_port_d;
      led_q      <= led_d;
      mask_q     <= mask_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ovf_q      <= ovf_d;
      irq_q      <= irq_d;
    end
  end

  assign in_port   = in_port_q;
  assign led_out   = led_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign interrupt = irq_q;

endmodule

// File: tb/tb_pico_io_port.sv
// Directed bench for pico_io_port: register/FIFO vector table plus multi-cycle sequences.
module tb_pico_io_port;

  logic       clk = 1'b0;
  logic       cpu_reset;
  logic [7:0] port_id, out_port, rx_data;
  logic       write_strobe, k_write_strobe, read_strobe;
  logic       interrupt_ack, rx_valid, tx_ready;
  logic [7:0] in_port, tx_data, led_out;
  logic       interrupt, rx_ready, tx_valid;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  pico_io_port #(.FIFO_DEPTH(4), .BASE_ID(8'h00)) dut (
    .clk            (clk),
    .cpu_reset      (cpu_reset),
    .port_id        (port_id),
    .out_port       (out_port),
    .write_strobe   (write_strobe),
    .k_write_strobe (k_write_strobe),
    .read_strobe    (read_strobe),
    .in_port        (in_port),
    .interrupt      (interrupt),
    .interrupt_ack  (interrupt_ack),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .led_out        (led_out)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want done");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] pid, dout;
    logic       ws, rs, rxv;
    logic [7:0] rxd;
    logic       chk_in;
    logic [7:0] e_in, e_led;
    logic       e_irq, e_rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [7:0] pid, logic [7:0] dout, logic ws, logic rs, logic rxv,
                              logic [7:0] rxd, logic chk_in, logic [7:0] e_in, logic [7:0] e_led,
                              logic e_irq, logic e_rdy);
    vec_t v;
    v.pid = pid; v.dout = dout; v.ws = ws; v.rs = rs; v.rxv = rxv; v.rxd = rxd;
    v.chk_in = chk_in; v.e_in = e_in; v.e_led = e_led; v.e_irq = e_irq; v.e_rdy = e_rdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // driver: apply one cycle of inputs, return #1 after the edge
  task automatic cyc(input logic [7:0] pid, input logic [7:0] dout, input logic ws, input logic rs,
                     input logic rxv, input logic [7:0] rxd, input logic txr, input logic ack,
                     input logic kws);
    port_id = pid; out_port = dout; write_strobe = ws; read_strobe = rs;
    rx_valid = rxv; rx_data = rxd; tx_ready = txr; interrupt_ack = ack; k_write_strobe = kws;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    cyc(8'h00, 8'h00, 0, 0, 1, d, 0, 0, 0);
  endtask

  task automatic pop_chk(input string name);
    logic [7:0] e;
    cyc(8'h01, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    chk(name, in_port, e);
  endtask

  task automatic rd(input logic [7:0] pid);
    cyc(pid, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
  endtask

  initial begin
    cpu_reset = 1'b1;
    port_id = 0; out_port = 0; write_strobe = 0; k_write_strobe = 0; read_strobe = 0;
    interrupt_ack = 0; rx_data = 0; rx_valid = 0; tx_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    cpu_reset = 1'b0;
    chk("rst_in_port", in_port, 8'h00);
    chk("rst_led", led_out, 8'h00);
    chk("rst_irq", {7'b0, interrupt}, 8'h00);
    chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
    chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);

    //               pid    dout   ws rs rxv rxd   ci  e_in   e_led  irq rdy
    tbl.push_back(mk(8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 0, 1));
    tbl.push_back(mk(8'h02, 8'hA5, 1, 0, 0, 8'h00, 1, 8'h00, 8'hA5, 0, 1));
    tbl.push_back(mk(8'h02, 8'h00, 0, 0, 0, 8'h00, 1, 8'hA5, 8'hA5, 0, 1));
    tbl.push_back(mk(8'h00, 8'h00, 0, 0, 1, 8'h11, 1, 8'h00, 8'hA5, 0, 1));
    tbl.push_back(mk(8'h00, 8'h00, 0, 0, 1, 8'h22, 1, 8'h01, 8'hA5, 0, 1));
    tbl.push_back(mk(8'h00, 8'h00, 0, 0, 1, 8'h33, 1, 8'h01, 8'hA5, 0, 1));
    tbl.push_back(mk(8'h00, 8'h00, 0, 0, 1, 8'h44, 1, 8'h01, 8'hA5, 0, 0));
    tbl.push_back(mk(8'h00, 8'h00, 0, 0, 1, 8'h55, 1, 8'h03, 8'hA5, 0, 0));
    tbl.push_back(mk(8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 8'h07, 8'hA5, 0, 0));
    tbl.push_back(mk(8'h01, 8'h00, 0, 1, 0, 8'h00, 1, 8'h11, 8'hA5, 0, 1));
    tbl.push_back(mk(8'h01, 8'h00, 0, 1, 0, 8'h00, 1, 8'h22, 8'hA5, 0, 1));
    tbl.push_back(mk(8'h01, 8'h00, 0, 1, 0, 8'h00, 1, 8'h33, 8'hA5, 0, 1));
    tbl.push_back(mk(8'h01, 8'h00, 0, 1, 0, 8'h00, 1, 8'h44, 8'hA5, 0, 1));
    tbl.push_back(mk(8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 8'h04, 8'hA5, 0, 1));
    tbl.push_back(mk(8'h00, 8'h04, 1, 0, 0, 8'h00, 1, 8'h04, 8'hA5, 0, 1));
    tbl.push_back(mk(8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00, 8'hA5, 0, 1));
    tbl.push_back(mk(8'h01, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 8'hA5, 0, 1));
    tbl.push_back(mk(8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00, 8'hA5, 0, 1));
    tbl.push_back(mk(8'h05, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00, 8'hA5, 0, 1));
    tbl.push_back(mk(8'h07, 8'hFF, 1, 0, 0, 8'h00, 1, 8'h00, 8'hA5, 0, 1));
    tbl.push_back(mk(8'h09, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00, 8'hA5, 0, 1));
    tbl.push_back(mk(8'h02, 8'h00, 0, 0, 0, 8'h00, 1, 8'hA5, 8'hA5, 0, 1));
    tbl.push_back(mk(8'h03, 8'hFF, 1, 0, 0, 8'h00, 1, 8'h00, 8'hA5, 0, 1));
    tbl.push_back(mk(8'h03, 8'h00, 0, 0, 0, 8'h00, 1, 8'h07, 8'hA5, 1, 1));
    tbl.push_back(mk(8'h03, 8'h00, 1, 0, 0, 8'h00, 1, 8'h07, 8'hA5, 1, 1));
    tbl.push_back(mk(8'h03, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00, 8'hA5, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].pid, tbl[i].dout, tbl[i].ws, tbl[i].rs, tbl[i].rxv, tbl[i].rxd, 0, 0, 0);
      if (tbl[i].chk_in) chk($sformatf("vec%0d_in_port", i), in_port, tbl[i].e_in);
      chk($sformatf("vec%0d_led", i), led_out, tbl[i].e_led);
      chk($sformatf("vec%0d_irq", i), {7'b0, interrupt}, {7'b0, tbl[i].e_irq});
      chk($sformatf("vec%0d_rx_ready", i), {7'b0, rx_ready}, {7'b0, tbl[i].e_rdy});
    end

    // push and pop at the same edge while full
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'hA1 + 8'(i));
      push(8'hA1 + 8'(i));
    end
    chk("pp_full_ready", {7'b0, rx_ready}, 8'h00);
    cyc(8'h01, 8'h00, 0, 1, 1, 8'h66, 0, 0, 0);
    chk("pp_pop_head", in_port, exp_q.pop_front());
    exp_q.push_back(8'h66);
    chk("pp_still_full", {7'b0, rx_ready}, 8'h00);
    rd(8'h00);
    chk("pp_status", in_port, 8'h03);
    for (int i = 0; i < 4; i++) pop_chk($sformatf("pp_drain%0d", i));
    rd(8'h00);
    chk("pp_status_empty", in_port, 8'h00);

    // overflow event wins over a same-edge clear
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'hB1 + 8'(i));
      push(8'hB1 + 8'(i));
    end
    cyc(8'h00, 8'h04, 1, 0, 1, 8'hB5, 0, 0, 0);
    rd(8'h00);
    chk("ovf_race_status", in_port, 8'h07);
    cyc(8'h00, 8'h04, 1, 0, 0, 8'h00, 0, 0, 0);
    rd(8'h00);
    chk("ovf_clear_status", in_port, 8'h03);
    for (int i = 0; i < 4; i++) pop_chk($sformatf("ovf_drain%0d", i));

    // TX register: load, ignored rewrite, handshake, reload
    cyc(8'h04, 8'h3C, 1, 0, 0, 8'h00, 0, 0, 0);
    chk("tx_load_valid", {7'b0, tx_valid}, 8'h01);
    chk("tx_load_data", tx_data, 8'h3C);
    cyc(8'h04, 8'h77, 1, 0, 0, 8'h00, 0, 0, 0);
    chk("tx_busy_data", tx_data, 8'h3C);
    chk("tx_busy_valid", {7'b0, tx_valid}, 8'h01);
    rd(8'h04);
    chk("tx_readback", in_port, 8'h3C);
    rd(8'h00);
    chk("tx_status", in_port, 8'h08);
    cyc(8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0);
    chk("tx_done_valid", {7'b0, tx_valid}, 8'h00);
    chk("tx_done_data", tx_data, 8'h3C);
    cyc(8'h04, 8'h77, 1, 0, 0, 8'h00, 0, 0, 0);
    chk("tx_reload_data", tx_data, 8'h77);
    chk("tx_reload_valid", {7'b0, tx_valid}, 8'h01);

    // constant-write qualifier
    cyc(8'h02, 8'h5A, 0, 0, 0, 8'h00, 0, 0, 1);
`ifdef PICO_IO_KWRITE_EN
    chk("kwrite_led", led_out, 8'h5A);
`else
    chk("kwrite_led", led_out, 8'hA5);
`endif
    cyc(8'h03, 8'h07, 0, 0, 0, 8'h00, 0, 0, 1);
    rd(8'h03);
    chk("kwrite_mask_ignored", in_port, 8'h00);

    // interrupt on RX data, ack drop and reassert
    cyc(8'h03, 8'h01, 1, 0, 0, 8'h00, 0, 0, 0);
    push(8'h5A);
    chk("irq_wait", {7'b0, interrupt}, 8'h00);
    rd(8'h00);
    chk("irq_set", {7'b0, interrupt}, 8'h01);
    cyc(8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0);
    chk("irq_ack", {7'b0, interrupt}, 8'h00);
    rd(8'h00);
    chk("irq_reassert", {7'b0, interrupt}, 8'h01);
    exp_q.push_back(8'h5A);
    pop_chk("irq_pop");
    rd(8'h00);
    chk("irq_cleared", {7'b0, interrupt}, 8'h00);

    // reset with a byte queued and a TX byte pending
    cyc(8'h03, 8'h07, 1, 0, 0, 8'h00, 0, 0, 0);
    push(8'hC3);
    cpu_reset = 1'b1;
    rd(8'h02);
    cpu_reset = 1'b0;
    chk("mid_rst_in_port", in_port, 8'h00);
    chk("mid_rst_led", led_out, 8'h00);
    chk("mid_rst_irq", {7'b0, interrupt}, 8'h00);
    chk("mid_rst_rx_ready", {7'b0, rx_ready}, 8'h01);
    chk("mid_rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("mid_rst_tx_data", tx_data, 8'h00);
    rd(8'h00);
    chk("mid_rst_status", in_port, 8'h00);
    rd(8'h03);
    chk("mid_rst_mask", in_port, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pico_io_port.md
PICO_IO_PORT -- requirements
Module: pico_io_port

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: RX FIFO entries; power of two, 2..16.
REQ-002 Parameter BASE_ID, default 8'h00: port_id of register 0; registers at BASE_ID+0..BASE_ID+4.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 cpu_reset  input  1  reset, synchronous, active-high.
REQ-005 port_id  input  8  CPU port address.
REQ-006 out_port  input  8  CPU write data.
REQ-007 write_strobe  input  1  CPU write qualifier.
REQ-008 k_write_strobe  input  1  CPU constant-write qualifier.
REQ-009 read_strobe  input  1  CPU read qualifier.
REQ-010 in_port  output  8  registered read data to CPU.
REQ-011 interrupt  output  1  interrupt request to CPU.
REQ-012 interrupt_ack  input  1  CPU interrupt acknowledge.
REQ-013 rx_data  input  8  external byte in; rx_valid  input  1; rx_ready  output  1.
REQ-014 tx_data  output  8  external byte out; tx_valid  output  1; tx_ready  input  1.
REQ-015 led_out  output  8  general-purpose output register.

Function
REQ-016 Register map (offset from BASE_ID): 0 STATUS (R; W1C on bit2), 1 RX_DATA (R, pops FIFO), 2 LED (R/W), 3 IRQ_MASK (R/W, bits 2:0), 4 TX_DATA (W; R returns last written value).
REQ-017 STATUS = {4'b0, tx_valid, rx_overflow, rx_full, rx_not_empty}.
REQ-018 in_port is updated every cycle from the current port_id (one-cycle latency); unmapped IDs return 8'h00.
REQ-019 A write occurs when write_strobe=1 and port_id matches; unmatched writes have no effect.
REQ-020 FIFO pop occurs when read_strobe=1 and port_id=BASE_ID+1 and FIFO not empty; a pop of an empty FIFO has no effect.
REQ-021 rx_ready = ~rx_full; a push occurs when rx_valid=1 and rx_ready=1.
REQ-022 Push and pop in the same cycle when full: both take effect, count unchanged, no overflow.
REQ-023 rx_valid=1 while full without a same-cycle pop: byte dropped, rx_overflow set (sticky).
REQ-024 rx_overflow clears on a write to STATUS with out_port[2]=1; a same-cycle overflow event wins (stays set).
REQ-025 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.
REQ-026 TX: a write to TX_DATA while tx_valid=0 loads tx_data and sets tx_valid the next cycle.
REQ-027 TX: a write to TX_DATA while tx_valid=1 is ignored and tx_data holds.
REQ-028 TX: tx_valid clears in the cycle after tx_valid=1 and tx_ready=1 coincide; tx_data is stable while tx_valid=1.
REQ-029 irq_cond = (rx_not_empty & mask[0]) | (rx_overflow & mask[1]) | (~tx_valid & mask[2]).
REQ-030 interrupt register: next = 0 if interrupt_ack=1, else irq_cond; it reasserts one cycle after ack if irq_cond persists.

Reset
REQ-031 While cpu_reset=1 at a clock edge: in_port=0, interrupt=0, led_out=0, IRQ_MASK=0, tx_valid=0, tx_data=0, FIFO emptied, rx_overflow=0; rx_ready=1 in the first cycle after reset.
REQ-032 Reset mid-transfer discards FIFO contents and any pending TX byte, with no tx_ready handshake required.

Configuration
REQ-033 Macro PICO_IO_KWRITE_EN defined: k_write_strobe is accepted as a write qualifier for LED and TX_DATA only.
REQ-034 PICO_IO_KWRITE_EN undefined: k_write_strobe is ignored entirely.

Structure
REQ-035 Package pico_io_pkg holds the register offset constants and STATUS bit-index constants.
REQ-036 The RX FIFO is a sub-module, pico_io_fifo (push, pop, data, full, empty, count); all other logic is in pico_io_port.

Verification
REQ-037 Reset, then read ID 0x00: in_port=8'h00, rx_ready=1, interrupt=0, led_out=8'h00.
REQ-038 Write 8'hA5 to ID 0x02: led_out=8'hA5 next cycle; read ID 0x02 returns 8'hA5.
REQ-039 Push 8'h11, 8'h22, 8'h33, 8'h44, then push 8'h55: rx_full=1, 8'h55 dropped, STATUS=8'h07. Pop four times: returns 11,22,33,44. Write 8'h04 to ID 0x00: STATUS=8'h00.
REQ-040 Push and pop in the same cycle when full: count stays 4, rx_overflow stays 0.
REQ-041 Write 8'h3C to ID 0x04 with tx_ready=0, then write 8'h77: tx_data stays 8'h3C. Raise tx_ready for one cycle: tx_valid=0 the next cycle.
REQ-042 IRQ_MASK=8'h01, push one byte: interrupt=1. Pulse interrupt_ack: interrupt=0 for one cycle, then 1 again. Pop the byte: interrupt=0.
